seg_scan_drv: RTL and testbench



---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_scan_drv_hex_dec.sv | 32 +++
 rtl/seg_scan_drv.sv | 125 ++++++++++++
 tb/tb_seg_scan_drv.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a} and the scan FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_drv_hex_dec.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_drv.sv
// 8-digit multiplexed seven-segment driver with per-slot dead time and
// frame-synchronous display update. SEG_LZ_BLANK_EN enables leading-zero blanking.
//
// state   | meaning
// S_RST   | held by rst; outputs idle
// S_BLANK | all anodes off, seg/dp preloaded for dig_idx
// S_DRIVE | anode dig_idx on until the slot ends
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        data_vld,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYC - 1);

  scan_state_t      state, state_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [BLK_W-1:0] blank_cnt;
  logic [2:0]       dig_idx;
  logic [39:0]      shadow, disp;
  logic             pend;
  logic             slot_tick, frame_wrap, lz_hide;
  logic [7:0]       an_nxt;
  logic [7:0]       disp_dp;
  logic [3:0]       nib;
  logic [6:0]       seg_dec;

  // The prescaler stays parked while in S_RST so the first slot is full length.
  assign slot_tick  = (state != S_RST) && (pre_cnt == PRE_LAST);
  assign frame_wrap = slot_tick && (dig_idx == 3'd7);
  assign disp_dp    = disp[39:32];
  assign nib        = disp[{dig_idx, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
  // A lit decimal point at or above digit k counts as significant.
  always_comb begin
    lz_hide = (dig_idx != 3'd0)
           && ((disp[31:0] >> {dig_idx, 2'b00}) == 32'd0)
           && ((disp_dp >> dig_idx) == 8'd0);
  end
`else
  assign lz_hide = 1'b0;
`endif

  seg_hex_dec u_hex_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    an_nxt    = 8'hFF;
    case (state)
      S_RST:   state_nxt = S_BLANK;
      S_BLANK: if (blank_cnt == '0) state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (!lz_hide) an_nxt = ~(8'h01 << dig_idx);
        if (slot_tick) state_nxt = S_BLANK;
      end
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      blank_cnt <= '0;
      dig_idx   <= 3'd0;
    end else begin
      if (state == S_RST || slot_tick) pre_cnt <= '0;
      else                             pre_cnt <= pre_cnt + 1'b1;
      if (state != S_BLANK)            blank_cnt <= BLK_LOAD;
      else if (blank_cnt != '0)        blank_cnt <= blank_cnt - 1'b1;
      if (slot_tick)                   dig_idx <= dig_idx + 3'd1;
    end
  end

  // A strobe coinciding with the wrap re-arms pend, so it lands one frame later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      disp   <= '0;
      pend   <= 1'b0;
    end else begin
      if (data_vld)          shadow <= {dp_in, data};
      if (frame_wrap && pend) disp  <= shadow;
      if (data_vld)          pend   <= 1'b1;
      else if (frame_wrap)   pend   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 8'hFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= (state == S_RST) ? SEG_OFF : seg_dec;
      dp         <= (state == S_RST) ? 1'b1 : ~disp_dp[dig_idx];
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv: directed and random strobes against a timeline model
// that derives slot/digit/frame from the cycle count since reset release.
module tb_seg_scan_drv;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        data_vld;
  logic [7:0]  dp_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int          n;
  int          errors = 0;
  int          checks = 0;
  int          st_e[$];
  logic [39:0] st_v[$];
  logic [6:0]  seg_t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_scan_drv #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_vld   (data_vld),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // Frame f is loaded at edge f*FR+1 with the last strobe captured since the previous load.
  function automatic logic [39:0] disp_of(int f);
    logic [39:0] v = '0;
    int lo, hi;
    for (int g = 1; g <= f; g++) begin
      lo = (g == 1) ? -1 : (g - 1) * FR + 1;
      hi = g * FR + 1;
      foreach (st_e[i])
        if (st_e[i] >= lo && st_e[i] < hi) v = st_v[i];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, hide;
    logic [39:0] v;
    logic [3:0]  nb;
    int          m, p, s, d, f;
    if (n <= 1) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      m  = n - 1;
      p  = (m - 1) % SD;
      s  = (m - 1) / SD;
      d  = s % 8;
      f  = s / 8;
      v  = disp_of(f);
      nb = v[4*d +: 4];
      e_seg = seg_t[nb];
      e_dp  = ~v[32+d];
      hide  = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      hide = (d >= 1) && ((v[31:0] >> (4*d)) == 32'd0) && ((v[39:32] >> d) == 8'd0);
`endif
      e_an = (p < BC || hide) ? 8'hFF : ~(8'h01 << d);
      e_fd = ((n - 1) % FR == 0);
    end
    chk("an", an, e_an);
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("dp", {7'd0, dp}, {7'd0, e_dp});
    chk("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
  endtask

  task automatic cyc(input logic vld, input logic [31:0] d, input logic [7:0] p);
    data_vld = vld;
    data     = d;
    dp_in    = p;
    if (vld) begin
      st_e.push_back(n + 1);
      st_v.push_back({p, d});
    end
    @(posedge clk);
    n++;
    #1;
    data_vld = 1'b0;
    check_outputs();
  endtask

  task automatic idle_to(input int e);
    while (n + 1 < e) cyc(1'b0, 32'd0, 8'd0);
  endtask

  task automatic strobe_at(input int e, input logic [31:0] d, input logic [7:0] p);
    idle_to(e);
    cyc(1'b1, d, p);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
    st_e.delete();
    st_v.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  rp;
    rst = 1'b1; data = '0; data_vld = 1'b0; dp_in = '0; n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    release_rst();

    strobe_at(2, 32'h76543210, 8'h00);
    strobe_at(FR + 6, 32'h00000000, 8'h00);
    strobe_at(2*FR + 11, 32'hAAAAAAAA, 8'h00);
    strobe_at(3*FR + 4, 32'h12340000, 8'h0F);
    strobe_at(3*FR + 9, 32'h5555CDEF, 8'h21);
    strobe_at(4*FR - 2, 32'h89ABCDEF, 8'h00);
    strobe_at(4*FR + 1, 32'h0BADF00D, 8'hFF);
    strobe_at(5*FR + 2, 32'h00000012, 8'h00);
    strobe_at(6*FR + 5, 32'h00000012, 8'h80);
    strobe_at(7*FR + 3, 32'h00000000, 8'h00);
    idle_to(9*FR + 2);

    for (int i = 0; i < 3 * FR; i++) begin
      if ($urandom_range(11) == 0) begin
        rd = $urandom;
        rp = 8'($urandom_range(255));
        if ($urandom_range(1) == 0) rd = rd >> (4 * $urandom_range(7));
        if ($urandom_range(1) == 0) rp = 8'h00;
        cyc(1'b1, rd, rp);
      end else begin
        cyc(1'b0, 32'd0, 8'd0);
      end
    end
    idle_to(n + FR + 2);

    // Asynchronous reset mid-frame with a pending strobe that must be dropped.
    strobe_at(n + 3, 32'hFEDCBA98, 8'hFF);
    cyc(1'b0, 32'd0, 8'd0);
    rst = 1'b1;
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'd0, dp}, 8'h01);
    chk("rst_fd", {7'd0, frame_done}, 8'h00);
    repeat (2) @(posedge clk);
    release_rst();
    idle_to(2*FR + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
